// File: rtl/rv_pkg.sv
// Shared RV32M definitions: operand width, M-op funct3 codes
// and the multiply/divide sequencer state encoding.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide
// on unsigned magnitudes, one step per enable.
module mdu_iter_core
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  logic [4:0]      count;
  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   msum;
  logic [XLEN:0]   rtry;
  logic [XLEN+1:0] diff;

  // acc = {high/remainder, low multiplier/quotient}
  assign msum = {1'b0, acc[2*XLEN-1:XLEN]}
              + (acc[0] ? {1'b0, b_q} : '0);
  assign rtry = acc[2*XLEN-1:XLEN-1];
  assign diff = {1'b0, rtry} - {2'b0, b_q};
  assign last = (count == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      b_q   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {{XLEN{1'b0}}, op_a};
      b_q   <= op_b;
      count <= '0;
    end else if (en) begin
      count <= count + 5'd1;
      if (!is_div)
        acc <= {msum, acc[XLEN-1:1]};
      else if (diff[XLEN+1])
        acc <= {rtry[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M unit: sequencer, sign handling, special
// cases and write-back registers around mdu_iter_core.
module mul_div_unit
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  state_t            state;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic              a_neg_q;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic              div0;
  logic              ovf;
  logic              special;
  logic              accept;
  logic              last;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   spec_val;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    a_sgn = funct3[2] ? !funct3[0] : (funct3 != F3_MULHU);
    b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
    a_neg = a_sgn & rs1_data[XLEN-1];
    b_neg = b_sgn & rs2_data[XLEN-1];
    a_mag = a_neg ? -rs1_data : rs1_data;
    b_mag = b_neg ? -rs2_data : rs2_data;
    div0  = funct3[2] && (rs2_data == '0);
    ovf   = funct3[2] && !funct3[0]
         && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
         && (rs2_data == '1);
    // overflow: DIV returns the dividend, REM returns zero
    if (div0)
      spec_val = funct3[1] ? rs1_data : '1;
    else
      spec_val = funct3[1] ? '0 : rs1_data;
  end

  assign special = div0 | ovf;
  assign accept  = (state == S_IDLE) && start && !kill;

  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = a_neg_q ? -acc[2*XLEN-1:XLEN]
                      : acc[2*XLEN-1:XLEN];
    fix_val = '0;
    unique case (1'b1)
      f3_q == F3_MUL:
        fix_val = prod[XLEN-1:0];
      !f3_q[2] && (f3_q != F3_MUL):
        fix_val = prod[2*XLEN-1:XLEN];
      f3_q[2] && !f3_q[1]:
        fix_val = quo;
      f3_q[2] && f3_q[1]:
        fix_val = rem;
    endcase
  end

  mdu_iter_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept && !special),
    .en     ((state == S_CALC) && !kill),
    .is_div (f3_q[2]),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .acc    (acc),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f3_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      a_neg_q   <= 1'b0;
      result    <= '0;
      result_rd <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            f3_q    <= funct3;
            rd_q    <= rd_addr;
            neg_q   <= a_neg ^ b_neg;
            a_neg_q <= a_neg;
            if (special) begin
              result    <= spec_val;
              result_rd <= rd_addr;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill)
            state <= S_IDLE;
          else if (last)
            state <= S_FIX;
        end
        S_FIX: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            result    <= fix_val;
            result_rd <= rd_q;
            state     <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M cases,
// handshake/abort/reset corners and a short random sweep.
module tb_mul_div_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  mul_div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kill      (kill),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_rd (result_rd)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb_;
    longint      ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub  = longint'({32'b0, b});
    model = '0;
    case (f)
      F3_MUL:    begin p = sa * sb_; model = p[31:0]; end
      F3_MULH:   begin p = sa * sb_; model = p[63:32]; end
      F3_MULHSU: begin p = sa * ub; model = p[63:32]; end
      F3_MULHU:  begin
        p = {32'b0, a} * {32'b0, b};
        model = p[63:32];
      end
      F3_DIV:  begin
        p = sa / ((b == 0) ? 64'sd1 : sb_);
        model = (b == 0) ? 32'hFFFF_FFFF : p[31:0];
      end
      F3_DIVU: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  begin
        p = sa % ((b == 0) ? 64'sd1 : sb_);
        model = (b == 0) ? a : p[31:0];
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // poke: 0 none, 1 re-assert start at cycle pc, 2 kill at cycle pc
  task automatic run_op(input string tag,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int lat,
                        input int poke,
                        input int pc);
    int   cyc;
    bit   seen;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    funct3 = f;
    rs1_data = a;
    rs2_data = b;
    rd_addr = rd;
    if (poke != 2) sb.push_back('{exp, rd, lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_addr = 5'($urandom);
    cyc = 1;
    seen = 0;
    while (cyc <= 40 && !seen) begin
      @(negedge clk);
      if (poke == 2 && cyc == pc + 1)
        chk_eq({tag, "_kill_busy"}, busy, 0);
      if (poke == 1 && cyc == pc) start = 1'b1;
      if (poke == 2 && cyc == pc) kill = 1'b1;
      if (done) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        start = 1'b0;
        kill = 1'b0;
        cyc++;
      end
    end
    if (poke == 2) begin
      chk_eq({tag, "_no_done"}, seen, 0);
      chk_eq({tag, "_res_hold"}, result, last_res);
      chk_eq({tag, "_rd_hold"}, result_rd, last_rd);
    end else begin
      e = sb.pop_front();
      chk_eq({tag, "_done"}, seen, 1);
      chk_eq({tag, "_res"}, result, e.res);
      chk_eq({tag, "_rd"}, result_rd, e.rd);
      chk_eq({tag, "_lat"}, cyc, e.lat);
      last_res = e.res;
      last_rd = e.rd;
      @(posedge clk);
      #1;
      chk_eq({tag, "_busy_after"}, busy, 0);
    end
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    bit          spc;

    #12;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_res", result, 0);
    chk_eq("rst_rd", result_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5,
           32'hFFFF_FFEB, 34, 0, 0);
    run_op("mulhu", F3_MULHU, '1, '1, 5'd1,
           32'hFFFF_FFFE, 34, 0, 0);
    run_op("mulh", F3_MULH, '1, '1, 5'd2,
           32'h0000_0000, 34, 0, 0);
    run_op("mulhsu", F3_MULHSU, '1, '1, 5'd3,
           32'hFFFF_FFFF, 34, 0, 0);
    run_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4,
           32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6,
           32'hFFFF_FFFF, 34, 0, 0);
    run_op("divu", F3_DIVU, 32'd100, 32'd7, 5'd7,
           32'h0000_000E, 34, 0, 0);
    run_op("remu", F3_REMU, 32'd100, 32'd7, 5'd8,
           32'h0000_0002, 34, 0, 0);

    run_op("div0", F3_DIV, 32'd5, 32'd0, 5'd9,
           32'hFFFF_FFFF, 1, 0, 0);
    run_op("remu0", F3_REMU, 32'd5, 32'd0, 5'd10,
           32'd5, 1, 0, 0);
    run_op("ovf_div", F3_DIV, 32'h8000_0000, '1, 5'd11,
           32'h8000_0000, 1, 0, 0);
    run_op("ovf_rem", F3_REM, 32'h8000_0000, '1, 5'd12,
           32'h0000_0000, 1, 0, 0);

    run_op("restart", F3_MUL, 32'h1234, 32'h10, 5'd13,
           32'h0001_2340, 34, 1, 10);
    run_op("kill", F3_MUL, 32'd9, 32'd9, 5'd14,
           32'd81, 34, 2, 10);

    @(negedge clk);
    start = 1'b1;
    kill = 1'b1;
    funct3 = F3_DIVU;
    rs1_data = 32'd50;
    rs2_data = 32'd0;
    rd_addr = 5'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill = 1'b0;
    @(negedge clk);
    chk_eq("ks_busy", busy, 0);
    chk_eq("ks_done", done, 0);
    chk_eq("ks_res", result, last_res);
    chk_eq("ks_rd", result_rd, last_rd);

    @(negedge clk);
    start = 1'b1;
    funct3 = F3_MUL;
    rs1_data = 32'd3;
    rs2_data = 32'd5;
    rd_addr = 5'd16;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_done", done, 0);
    chk_eq("mid_rst_res", result, 0);
    chk_eq("mid_rst_rd", result_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    last_rd = '0;
    run_op("post_rst_divu", F3_DIVU, 32'd100, 32'd7, 5'd17,
           32'h0000_000E, 34, 0, 0);

    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i == 5) begin
        a = $urandom_range(0, 1000);
        b = $urandom_range(1, 20);
      end
      spc = f[2] && (b == 0 ||
            (!f[0] && a == 32'h8000_0000 && b == '1));
      run_op($sformatf("rnd%0d", i), f, a, b,
             5'($urandom_range(1, 31)), model(f, a, b),
             spc ? 1 : 34, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit for the single-cycle core.
- It consumes the two source operands read from the register file, together with the destination register address.
- It computes over multiple cycles and returns the result and destination address aligned for the register-file write port.
- The core stalls on `busy` and writes back on the `done` pulse.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- kill  input  1  synchronous abort (pipeline flush).
- funct3  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  32  operand A (dividend / multiplicand).
- rs2_data  input  32  operand B (divisor / multiplier).
- rd_addr  input  5  destination register, captured with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  write-back data.
- result_rd  output  5  destination captured at start.

## Operation
States and transitions:
- IDLE: on start && !kill, capture funct3, rd_addr and operand magnitudes.
  - If the op is special, go to DONE.
  - Otherwise go to CALC with count=0.
- CALC: one radix-2 step per cycle for 32 cycles; at count==31, go to FIX.
  - Multiply: shift-add on magnitudes into a 64-bit product.
  - Divide: restoring, on magnitudes.
- FIX: apply sign correction, select the high or low product word (or quotient/remainder), register `result`; go to DONE.
- DONE: `done`=1 for exactly one cycle; go to IDLE.

Signedness rules:
- MUL, MULH, DIV, REM: both operands signed.
- MULHSU: A signed, B unsigned.
- MULHU, DIVU, REMU: both unsigned.
- Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.

Special cases (resolved combinationally from the inputs, registered at the start edge):
- Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.

Handshake and boundary behaviour:
- `start` outside IDLE is ignored; no queuing.
- `kill` in any non-IDLE state: IDLE at the next edge, no `done`; `result`/`result_rd` hold their previous values.
- `kill` and `start` together in IDLE: kill wins, start is dropped.
- `result` and `result_rd` hold from DONE until the next accepted start.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Normal op: `busy` high cycles 1–34; `done` high in cycle 34; next start accepted in cycle 35.
  - Total latency XLEN+2 = 34 cycles.
- Special op: `done` and `busy` high in cycle 1 only; latency 1.
- Reset (rst_n low): takes effect immediately, asynchronously, including mid-CALC. State goes to IDLE and count to 0; busy=0, done=0, result=0, result_rd=0.
- First start is accepted on the first rising edge with rst_n high.

## Structure
- Shared package `rv_pkg`:
  - funct3 constants for the eight M-ops;
  - state encoding (IDLE, CALC, FIX, DONE);
  - the XLEN constant.
- One sub-module is natural: `mdu_iter_core`. It holds the 64-bit accumulator/remainder, the shift registers and the 5-bit step counter, and performs one multiply or divide step per enable.
- The top level holds the FSM, operand sign handling, special-case detection and output registers.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (−3), rd=5 -> done in cycle 34, result=0xFFFFFFEB, result_rd=5, busy low in cycle 35.
- rs1=rs2=0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE;
  - MULH -> 0x00000000;
  - MULHSU -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV −7/2 -> 0xFFFFFFFD;
  - REM −7/2 -> 0xFFFFFFFF;
  - DIVU 100/7 -> 0x0000000E;
  - REMU 100/7 -> 0x00000002.
- Special cases, each with done in cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM of the same operands -> 0.
- Handshake:
  - start re-asserted in cycle 10 of a MUL -> ignored, original result unchanged;
  - kill in cycle 10 -> IDLE in cycle 11, no done pulse;
  - kill+start together in IDLE -> no op.
- Reset: rst_n low mid-CALC (cycle 20) -> busy/done/result/result_rd = 0 before the next clock edge. After release, DIVU 100/7 completes with 0x0000000E in cycle 34.
